// File: rtl/ofdm_pkg.sv
// ofdm_pkg -- shared definitions for the OFDM receive front end.
//   cp_state_t      : control state of the cyclic-prefix remover
//   NFFT_LOG2_MIN   : smallest supported log2 FFT size (128 points)
//   NFFT_LOG2_MAX   : largest supported log2 FFT size (4096 points)
//   CP_LEN_W        : width of cyclic-prefix length / sample counter
//   nfft_in_range() : legality test for a requested log2 FFT size
package ofdm_pkg;

    localparam int NFFT_LOG2_MIN = 7;
    localparam int NFFT_LOG2_MAX = 12;
    localparam int CP_LEN_W      = 16;
    localparam int SYM_CNT_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_SKIP_CP = 3'd2,
        ST_PASS    = 3'd3,
        ST_DONE    = 3'd4
    } cp_state_t;

    // max_log2 is passed in so an instance can narrow the supported range.
    function automatic logic nfft_in_range(input logic [4:0] nfft, input int max_log2);
        return (int'(nfft) >= NFFT_LOG2_MIN) && (int'(nfft) <= max_log2);
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf -- two-entry AXI-stream register slice carrying data + tlast.
//   aclk, areset           : clock, synchronous active-high reset
//   s_tdata/s_tlast/s_tvalid/s_tready : upstream side
//   m_tdata/m_tlast/m_tvalid/m_tready : downstream side (fully registered)
//   empty                  : no beat held in either entry
// s_tready is registered (not full == skid entry free), so the upstream
// ready path never combinationally depends on m_tready.
module axis_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              empty
);

    logic [DATA_W-1:0] main_data_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic              main_last_reg;
    logic              skid_last_reg;
    logic              main_valid_reg;
    logic              skid_valid_reg;

    always_ff @(posedge aclk) begin
        if (areset) begin
            main_data_reg  <= '0;
            skid_data_reg  <= '0;
            main_last_reg  <= 1'b0;
            skid_last_reg  <= 1'b0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (!main_valid_reg || m_tready) begin
            // Output entry frees up this cycle; the skid entry (older) has
            // priority. While the skid entry is occupied s_tready is low,
            // so no upstream beat can arrive at the same time.
            if (skid_valid_reg) begin
                main_data_reg  <= skid_data_reg;
                main_last_reg  <= skid_last_reg;
                main_valid_reg <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else begin
                main_valid_reg <= s_tvalid;
                if (s_tvalid) begin
                    main_data_reg <= s_tdata;
                    main_last_reg <= s_tlast;
                end
            end
        end else if (s_tvalid && !skid_valid_reg) begin
            // Output stalled: park the incoming beat in the skid entry.
            skid_data_reg  <= s_tdata;
            skid_last_reg  <= s_tlast;
            skid_valid_reg <= 1'b1;
        end
    end

    assign s_tready = !skid_valid_reg;
    assign m_tdata  = main_data_reg;
    assign m_tlast  = main_valid_reg && main_last_reg;
    assign m_tvalid = main_valid_reg;
    assign empty    = !main_valid_reg && !skid_valid_reg;

endmodule

// File: rtl/cp_remove.sv
// cp_remove -- strips the cyclic prefix from each OFDM symbol and forwards
// the 2^nfft useful samples to the FFT with tlast on the final sample.
//   aclk, areset            : clock, synchronous active-high reset
//   config_start            : latch nfft/cp_len/symbols/continuous (IDLE only)
//   nfft [4:0]              : log2 FFT size, legal 7..NFFT_LOG2_MAX
//   cp_len [15:0]           : cyclic-prefix length in samples
//   symbols [31:0]          : symbols per burst (ignored when continuous)
//   continuous              : run until stop instead of counting symbols
//   start                   : timing-sync pulse; next accepted beat is CP
//   stop                    : finish the symbol in flight, then end burst
//   s_axis_*                : time-domain input stream
//   m_axis_*                : FFT-input stream, tlast per symbol
//   busy / done / cfg_err   : status; done pulses once per burst, cfg_err sticky
module cp_remove #(
    parameter int DATA_W        = 32,
    parameter int NFFT_LOG2_MAX = ofdm_pkg::NFFT_LOG2_MAX
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              config_start,
    input  logic [4:0]        nfft,
    input  logic [15:0]       cp_len,
    input  logic [31:0]       symbols,
    input  logic              continuous,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    import ofdm_pkg::*;

    cp_state_t             state_reg, state_next;
    logic [CP_LEN_W-1:0]   samp_cnt_reg, samp_cnt_next;
    logic [SYM_CNT_W-1:0]  sym_cnt_reg, sym_cnt_next;
    logic [CP_LEN_W-1:0]   cp_len_reg;
    logic [CP_LEN_W-1:0]   nfft_last_reg;
    logic [SYM_CNT_W-1:0]  symbols_reg;
    logic                  continuous_reg;
    logic                  stop_seen_reg;
    logic                  cfg_err_reg;

    logic                  nfft_ok;
    logic [CP_LEN_W-1:0]   nfft_last_calc;

    logic                  buf_in_valid;
    logic                  buf_in_ready;
    logic                  buf_in_last;
    logic                  buf_empty;

    assign nfft_ok        = nfft_in_range(nfft, NFFT_LOG2_MAX);
    // Index of the last useful sample, stored so the hot compare is a plain
    // equality against a register rather than a shifter.
    assign nfft_last_calc = CP_LEN_W'((32'd1 << nfft) - 32'd1);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg      <= ST_IDLE;
            samp_cnt_reg   <= '0;
            sym_cnt_reg    <= '0;
            cp_len_reg     <= '0;
            nfft_last_reg  <= '0;
            symbols_reg    <= '0;
            continuous_reg <= 1'b0;
            stop_seen_reg  <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            samp_cnt_reg <= samp_cnt_next;
            sym_cnt_reg  <= sym_cnt_next;

            if (state_reg == ST_IDLE && config_start) begin
                if (nfft_ok) begin
                    cp_len_reg     <= cp_len;
                    nfft_last_reg  <= nfft_last_calc;
                    symbols_reg    <= symbols;
                    continuous_reg <= continuous;
                end else begin
                    cfg_err_reg <= 1'b1;
                end
            end

            // A stop seen anywhere in the burst is remembered until the
            // current symbol's final sample has been forwarded.
            if (state_reg == ST_IDLE) begin
                stop_seen_reg <= 1'b0;
            end else if (stop) begin
                stop_seen_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        samp_cnt_next = samp_cnt_reg;
        sym_cnt_next  = sym_cnt_reg;
        s_axis_tready = 1'b0;
        buf_in_valid  = 1'b0;
        buf_in_last   = 1'b0;
        done          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (config_start && nfft_ok) begin
                    state_next    = ST_ARMED;
                    samp_cnt_next = '0;
                    sym_cnt_next  = '0;
                end
            end

            ST_ARMED: begin
                // Drain pre-sync samples so the source never backs up.
                s_axis_tready = 1'b1;
                if (start) begin
                    samp_cnt_next = '0;
                    if (symbols_reg == '0 && !continuous_reg) begin
                        state_next = ST_DONE;
                    end else if (cp_len_reg == '0) begin
                        state_next = ST_PASS;
                    end else begin
                        state_next = ST_SKIP_CP;
                    end
                end
            end

            ST_SKIP_CP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    if (samp_cnt_reg == cp_len_reg - 16'd1) begin
                        samp_cnt_next = '0;
                        state_next    = ST_PASS;
                    end else begin
                        samp_cnt_next = samp_cnt_reg + 1'b1;
                    end
                end
            end

            ST_PASS: begin
                s_axis_tready = buf_in_ready;
                buf_in_valid  = s_axis_tvalid;
                buf_in_last   = (samp_cnt_reg == nfft_last_reg);
                if (s_axis_tvalid && buf_in_ready) begin
                    if (samp_cnt_reg == nfft_last_reg) begin
                        samp_cnt_next = '0;
                        sym_cnt_next  = sym_cnt_reg + 32'd1;
                        if (stop_seen_reg || stop ||
                            (!continuous_reg && (sym_cnt_reg + 32'd1 == symbols_reg))) begin
                            state_next = ST_DONE;
                        end else if (cp_len_reg == '0) begin
                            state_next = ST_PASS;
                        end else begin
                            state_next = ST_SKIP_CP;
                        end
                    end else begin
                        samp_cnt_next = samp_cnt_reg + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                // Hold off done until the last symbol has left the slice.
                if (buf_empty) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    axis_skid_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .aclk     (aclk),
        .areset   (areset),
        .s_tdata  (s_axis_tdata),
        .s_tlast  (buf_in_last),
        .s_tvalid (buf_in_valid),
        .s_tready (buf_in_ready),
        .m_tdata  (m_axis_tdata),
        .m_tlast  (m_axis_tlast),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready),
        .empty    (buf_empty)
    );

    assign busy    = (state_reg != ST_IDLE);
    assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_cp_remove.sv
// tb_cp_remove -- randomized self-checking bench for cp_remove. Expected
// output of every burst is derived from the symbol framing rules: symbol k
// occupies input indices k*(cp+N) .. k*(cp+N)+cp+N-1, its last N samples are
// forwarded and the very last one carries tlast.
module tb_cp_remove;

    localparam int DATA_W = 32;

    logic              aclk = 1'b0;
    logic              areset;
    logic              config_start;
    logic [4:0]        nfft;
    logic [15:0]       cp_len;
    logic [31:0]       symbols;
    logic              continuous;
    logic              start;
    logic              stop;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              busy;
    logic              done;
    logic              cfg_err;

    cp_remove #(
        .DATA_W        (DATA_W),
        .NFFT_LOG2_MAX (12)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .config_start  (config_start),
        .nfft          (nfft),
        .cp_len        (cp_len),
        .symbols       (symbols),
        .continuous    (continuous),
        .start         (start),
        .stop          (stop),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    always #5 aclk = ~aclk;

    longint cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- source, sink-ready and monitor processes -------------
    logic [31:0]  src_arr[$];
    int           src_len   = 0;
    bit           src_en    = 1'b0;
    int           src_idx   = 0;
    int           valid_pct = 100;
    int           ready_pct = 100;
    longint       acc_cyc[$];
    logic [32:0]  got_q[$];
    longint       got_cyc[$];
    int           done_cnt  = 0;
    int           drop_cnt  = 0;
    int           stab_viol = 0;

    initial begin
        bit acc;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        forever begin
            @(negedge aclk);
            acc = s_axis_tvalid && s_axis_tready;
            if (acc && src_en) acc_cyc.push_back(cyc);
            @(posedge aclk);
            #2;
            if (!src_en) begin
                src_idx       = 0;
                s_axis_tvalid = 1'b0;
            end else begin
                if (acc) src_idx++;
                if (src_idx < src_len) begin
                    if (!s_axis_tvalid || acc)
                        s_axis_tvalid = ($urandom_range(0, 99) < valid_pct);
                    s_axis_tdata = src_arr[src_idx];
                end else begin
                    s_axis_tvalid = 1'b0;
                end
            end
        end
    end

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #2;
            m_axis_tready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    initial begin
        bit          prev_stall;
        logic [32:0] prev_beat;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} != prev_beat))
                    stab_viol++;
                if (m_axis_tvalid && m_axis_tready) begin
                    got_q.push_back({m_axis_tlast, m_axis_tdata});
                    got_cyc.push_back(cyc);
                end
                if (done) done_cnt++;
                if (busy && s_axis_tvalid && !s_axis_tready) drop_cnt++;
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_beat  = {m_axis_tlast, m_axis_tdata};
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic do_config(input int lg, input int cp, input int syms, input bit cont);
        @(posedge aclk); #1;
        config_start = 1'b1;
        nfft         = 5'(lg);
        cp_len       = 16'(cp);
        symbols      = 32'(syms);
        continuous   = cont;
        @(posedge aclk); #1;
        config_start = 1'b0;
    endtask

    task automatic do_start();
        @(posedge aclk); #1;
        start = 1'b1;
        @(posedge aclk); #1;
        start  = 1'b0;
        src_en = 1'b1;
    endtask

    task automatic load_source(input int len, input bit ramp);
        src_arr.delete();
        for (int i = 0; i < len; i++) src_arr.push_back(ramp ? 32'(i) : $urandom);
        src_len = len;
    endtask

    // One complete burst. stop_sym > 0 selects continuous mode with stop
    // pulsed halfway through symbol number stop_sym (1-based).
    task automatic run_burst(input string tag, input int lg, input int cp, input int syms,
                             input int stop_sym, input bit ramp, input int vpct, input int rpct);
        int          n;
        int          per;
        int          nsym;
        int          base;
        int          done0;
        int          drop0;
        int          budget;
        int          stop_beat;
        bit          cont;
        bit          stop_sent;
        logic [32:0] exp_q[$];

        n     = 1 << lg;
        per   = cp + n;
        cont  = (stop_sym > 0);
        nsym  = cont ? stop_sym : syms;
        load_source(cont ? (nsym + 2) * per : syms * per, ramp);
        for (int k = 0; k < nsym; k++)
            for (int j = 0; j < n; j++)
                exp_q.push_back({(j == n - 1), src_arr[k * per + cp + j]});

        base      = got_q.size();
        done0     = done_cnt;
        drop0     = drop_cnt;
        stop_beat = (nsym - 1) * n + n / 2;
        stop_sent = 1'b0;
        budget    = 8 * src_len + 500;
        acc_cyc.delete();
        valid_pct = vpct;
        ready_pct = rpct;

        do_config(lg, cp, syms, cont);
        @(negedge aclk);
        check_eq({tag, "_armed_busy"}, busy, 1);
        do_start();

        for (int c = 0; c < budget && done_cnt == done0; c++) begin
            @(posedge aclk); #1;
            stop = 1'b0;
            if (cont && !stop_sent && (got_q.size() - base) >= stop_beat) begin
                stop      = 1'b1;
                stop_sent = 1'b1;
            end
        end
        @(posedge aclk); #1;
        stop = 1'b0;
        check_eq({tag, "_done_seen"}, (done_cnt > done0), 1);
        repeat (4) @(posedge aclk);
        #1;
        src_en    = 1'b0;
        ready_pct = 100;
        @(negedge aclk);
        check_eq({tag, "_done_once"}, done_cnt - done0, 1);
        check_eq({tag, "_idle"}, busy, 0);
        check_eq({tag, "_beats"}, got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < got_q.size())
                check_eq($sformatf("%s_beat%0d", tag, i), got_q[base + i], exp_q[i]);
        if (rpct == 100 && exp_q.size() > 0 && acc_cyc.size() > cp)
            check_eq({tag, "_latency"}, got_cyc[base] - acc_cyc[cp], 1);
        if (rpct < 100 && vpct == 100 && exp_q.size() > 0)
            check_eq({tag, "_backpressure"}, (drop_cnt > drop0), 1);
        check_eq({tag, "_stable"}, stab_viol, 0);
        $display("burst %s: nfft=%0d cp=%0d symbols=%0d expected_beats=%0d got_beats=%0d",
                 tag, lg, cp, nsym, exp_q.size(), got_q.size() - base);
    endtask

    // ---------------- main sequence ----------------------------------------
    initial begin
        int base;
        int done0;

        areset       = 1'b1;
        config_start = 1'b0;
        nfft         = '0;
        cp_len       = '0;
        symbols      = '0;
        continuous   = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_m_tvalid", m_axis_tvalid, 0);
        check_eq("rst_m_tlast", m_axis_tlast, 0);
        check_eq("rst_s_tready", s_axis_tready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cfg_err", cfg_err, 0);
        @(posedge aclk); #1;
        areset = 1'b0;

        run_burst("ramp_cp32", 7, 32, 2, 0, 1'b1, 100, 100);
        run_burst("ramp_cp0", 7, 0, 1, 0, 1'b1, 100, 100);
        run_burst("ramp_bp", 7, 32, 2, 0, 1'b1, 100, 50);
        run_burst("stop_sym3", 8, 64, 1, 3, 1'b0, 100, 100);
        run_burst("zero_sym", 7, 16, 0, 0, 1'b0, 100, 100);
        for (int r = 0; r < 3; r++)
            run_burst($sformatf("rand%0d", r), $urandom_range(7, 8), $urandom_range(0, 40),
                      $urandom_range(1, 3), 0, 1'b0, 70, 60);

        // Reset in the middle of a symbol's forwarded samples.
        base = got_q.size();
        load_source(2 * (16 + 128), 1'b0);
        do_config(7, 16, 2, 1'b0);
        do_start();
        for (int c = 0; c < 2000 && (got_q.size() - base) < 50; c++) @(posedge aclk);
        check_eq("rst_mid_reached", (got_q.size() - base) >= 50, 1);
        @(posedge aclk); #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        src_en = 1'b0;
        @(negedge aclk);
        check_eq("rst_mid_m_tvalid", m_axis_tvalid, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_s_tready", s_axis_tready, 0);
        run_burst("after_rst", 7, 8, 1, 0, 1'b0, 100, 100);

        // Illegal FFT size: flagged, no burst, start ignored.
        base  = got_q.size();
        done0 = done_cnt;
        do_config(13, 16, 1, 1'b0);
        @(negedge aclk);
        check_eq("nfft13_cfg_err", cfg_err, 1);
        check_eq("nfft13_busy", busy, 0);
        load_source(200, 1'b0);
        do_start();
        repeat (100) @(posedge aclk);
        #1;
        src_en = 1'b0;
        @(negedge aclk);
        check_eq("nfft13_no_output", got_q.size() - base, 0);
        check_eq("nfft13_no_done", done_cnt - done0, 0);
        check_eq("nfft13_still_idle", busy, 0);
        @(posedge aclk); #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check_eq("cfg_err_cleared", cfg_err, 0);
        do_config(6, 0, 1, 1'b0);
        @(negedge aclk);
        check_eq("nfft6_cfg_err", cfg_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
